// File: rtl/sdram_chip_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_chip_responder                                         |
// | Description : Device-side model of a 16-bit SDR SDRAM. Decodes commands,   |
// |               tracks open rows per bank, honours CAS latency and burst     |
// |               length, and serves bursts from a small on-chip array.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_chip_responder #(
  parameter int ROW_KEEP = 3,
  parameter int COL_KEEP = 7
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sdram_cke,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        mode_done,
  output logic        proto_err,
  output logic [15:0] aref_cnt
);

  localparam int c_AW    = 2 + ROW_KEEP + COL_KEEP;
  localparam int c_DEPTH = 1 << c_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_BST, CMD_PRE, CMD_AREF, CMD_MRS
  } cmd_t;

  // Storage and registered state
  logic [15:0]         mem [c_DEPTH];
  state_t              state_q, state_d;
  logic [3:0]          bank_open_q;
  logic [12:0]         bank_row_q [4];
  logic [2:0]          bl_q;
  logic                cl3_q;
  logic                mode_done_q;
  logic                proto_err_q;
  logic [15:0]         aref_cnt_q;
  logic [1:0]          burst_ba_q, burst_ba_d;
  logic [ROW_KEEP-1:0] burst_row_q, burst_row_d;
  logic [8:0]          col_q, col_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          pipe_v_q;
  logic [c_AW-1:0]     pipe_idx_q [3];
  logic [15:0]         dq_out_q;
  logic                dq_oe_q;

  // Combinational wires
  cmd_t                w_cmd;
  logic                w_rw_cmd, w_rw_ok, w_rw_bad, w_busy, w_stop, w_page;
  logic                w_mrs_ok, w_err;
  logic [2:0]          w_bl_m1;
  logic                w_acc_en, w_acc_wr;
  logic [1:0]          w_acc_ba;
  logic [ROW_KEEP-1:0] w_acc_row;
  logic [8:0]          w_acc_col;
  logic [2:0]          w_acc_left;
  logic [c_AW-1:0]     w_idx;
  logic                w_tap_v;
  logic [c_AW-1:0]     w_tap_idx;

  // Column step: page mode wraps over the full row, short bursts wrap in their aligned block
  function automatic logic [8:0] next_col(input logic [8:0] c, input logic [2:0] bl);
    logic [8:0] m;
    case (bl)
      3'b001:  m = 9'd1;
      3'b010:  m = 9'd3;
      3'b011:  m = 9'd7;
      default: m = 9'h1FF;
    endcase
    return (c & ~m) | ((c + 9'd1) & m);
  endfunction

  // Command decode; clock-enable low or deselect both collapse to NOP
  always_comb begin
    w_cmd = CMD_NOP;
    if (sdram_cke && !sdram_cs_n) begin
      case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
        3'b011:  w_cmd = CMD_ACT;
        3'b101:  w_cmd = CMD_READ;
        3'b100:  w_cmd = CMD_WRITE;
        3'b110:  w_cmd = CMD_BST;
        3'b010:  w_cmd = CMD_PRE;
        3'b001:  w_cmd = CMD_AREF;
        3'b000:  w_cmd = CMD_MRS;
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  // Burst length minus one for the fixed-length modes; page mode ignores it
  always_comb begin
    w_page = (bl_q == 3'b111);
    case (bl_q)
      3'b001:  w_bl_m1 = 3'd1;
      3'b010:  w_bl_m1 = 3'd3;
      3'b011:  w_bl_m1 = 3'd7;
      default: w_bl_m1 = 3'd0;
    endcase
  end

  assign w_rw_cmd = (w_cmd == CMD_READ) || (w_cmd == CMD_WRITE);
  assign w_rw_ok  = w_rw_cmd && bank_open_q[sdram_ba] && mode_done_q;
  assign w_rw_bad = w_rw_cmd && !w_rw_ok;
  assign w_busy   = (state_q != ST_IDLE);
  assign w_stop   = (w_cmd == CMD_BST) ||
                    ((w_cmd == CMD_PRE) && (sdram_addr[10] || (sdram_ba == burst_ba_q)));
  assign w_mrs_ok = !(|bank_open_q) &&
                    ((sdram_addr[2:0] <= 3'b011) || (sdram_addr[2:0] == 3'b111)) &&
                    ((sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3));
  assign w_err    = ((w_cmd == CMD_ACT)  && bank_open_q[sdram_ba]) ||
                    ((w_cmd == CMD_MRS)  && !w_mrs_ok) ||
                    ((w_cmd == CMD_AREF) && (|bank_open_q)) ||
                    w_rw_bad;

  // Next-state and per-cycle array access: a valid RD/WR starts a new burst, otherwise an
  // active burst advances unless BST/PRE stops it or the clock is disabled
  always_comb begin
    state_d     = state_q;
    burst_ba_d  = burst_ba_q;
    burst_row_d = burst_row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    w_acc_en    = 1'b0;
    w_acc_wr    = 1'b0;
    w_acc_ba    = burst_ba_q;
    w_acc_row   = burst_row_q;
    w_acc_col   = col_q;
    w_acc_left  = cnt_q;
    if (w_rw_ok) begin
      w_acc_en    = 1'b1;
      w_acc_wr    = (w_cmd == CMD_WRITE);
      w_acc_ba    = sdram_ba;
      w_acc_row   = bank_row_q[sdram_ba][ROW_KEEP-1:0];
      w_acc_col   = sdram_addr[8:0];
      w_acc_left  = w_bl_m1;
      burst_ba_d  = sdram_ba;
      burst_row_d = bank_row_q[sdram_ba][ROW_KEEP-1:0];
      state_d     = (w_cmd == CMD_WRITE) ? ST_WRITE : ST_READ;
    end else if (w_busy && w_stop) begin
      state_d = ST_IDLE;
    end else if (w_busy && sdram_cke) begin
      w_acc_en = 1'b1;
      w_acc_wr = (state_q == ST_WRITE);
    end
    if (w_acc_en) begin
      col_d = next_col(w_acc_col, bl_q);
      cnt_d = w_acc_left - 3'd1;
      if (!w_page && (w_acc_left == 3'd0)) begin
        state_d = ST_IDLE;
      end
    end
  end

  assign w_idx     = {w_acc_ba, w_acc_row, w_acc_col[COL_KEEP-1:0]};
  assign w_tap_v   = cl3_q ? pipe_v_q[2]   : pipe_v_q[1];
  assign w_tap_idx = cl3_q ? pipe_idx_q[2] : pipe_idx_q[1];

  // FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Array write port with per-byte masking; contents survive reset
  always_ff @(posedge sys_clk) begin
    if (w_acc_en && w_acc_wr) begin
      if (!sdram_dqm[0]) mem[w_idx][7:0]  <= dq_in[7:0];
      if (!sdram_dqm[1]) mem[w_idx][15:8] <= dq_in[15:8];
    end
  end

  // Bank/mode bookkeeping, burst counters, read pipeline and registered read data
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bank_open_q <= 4'b0000;
      for (int b = 0; b < 4; b++) bank_row_q[b] <= 13'd0;
      bl_q        <= 3'b111;
      cl3_q       <= 1'b1;
      mode_done_q <= 1'b0;
      proto_err_q <= 1'b0;
      aref_cnt_q  <= 16'd0;
      burst_ba_q  <= 2'd0;
      burst_row_q <= '0;
      col_q       <= 9'd0;
      cnt_q       <= 3'd0;
      pipe_v_q    <= 3'b000;
      for (int s = 0; s < 3; s++) pipe_idx_q[s] <= '0;
      dq_out_q    <= 16'd0;
      dq_oe_q     <= 1'b0;
    end else begin
      burst_ba_q  <= burst_ba_d;
      burst_row_q <= burst_row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      if (w_err) proto_err_q <= 1'b1;
      case (w_cmd)
        CMD_ACT: begin
          bank_row_q[sdram_ba]  <= sdram_addr;
          bank_open_q[sdram_ba] <= 1'b1;
        end
        CMD_PRE: begin
          if (sdram_addr[10]) bank_open_q <= 4'b0000;
          else                bank_open_q[sdram_ba] <= 1'b0;
        end
        CMD_AREF: aref_cnt_q <= aref_cnt_q + 16'd1;
        CMD_MRS: begin
          if (w_mrs_ok) begin
            bl_q        <= sdram_addr[2:0];
            cl3_q       <= (sdram_addr[6:4] == 3'd3);
            mode_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (sdram_cke) begin
        pipe_v_q      <= {pipe_v_q[1:0], w_acc_en && !w_acc_wr};
        pipe_idx_q[0] <= w_idx;
        pipe_idx_q[1] <= pipe_idx_q[0];
        pipe_idx_q[2] <= pipe_idx_q[1];
        dq_out_q      <= mem[w_tap_idx];
        dq_oe_q       <= w_tap_v;
      end
    end
  end

  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign mode_done = mode_done_q;
  assign proto_err = proto_err_q;
  assign aref_cnt  = aref_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_chip_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sdram_chip_responder                                      |
// | Description : Directed self-checking bench for sdram_chip_responder.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sdram_chip_responder;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = 2'd0;
  logic [12:0] addr = 13'd0;
  logic [1:0]  dqm = 2'b00;
  logic [15:0] dq_in = 16'd0;
  logic [15:0] dq_out;
  logic        dq_oe, mode_done, proto_err;
  logic [15:0] aref_cnt;

  int tests = 0;
  int fails = 0;

  sdram_chip_responder #(.ROW_KEEP(3), .COL_KEEP(7)) dut (
    .sys_clk(clk), .sys_rst(rst), .sdram_cke(cke), .sdram_cs_n(cs_n),
    .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_ba(ba),
    .sdram_addr(addr), .sdram_dqm(dqm), .dq_in(dq_in), .dq_out(dq_out),
    .dq_oe(dq_oe), .mode_done(mode_done), .proto_err(proto_err), .aref_cnt(aref_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b; addr = a; dq_in = d; dqm = m;
    tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    {cs_n, ras_n, cas_n, we_n} = NOP;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_oe", dq_oe, 16'd0);
    chk("rst_dq", dq_out, 16'd0);
    chk("rst_mode", mode_done, 16'd0);
    chk("rst_perr", proto_err, 16'd0);
    chk("rst_aref", aref_cnt, 16'd0);

    // Refresh with all banks closed
    drive(REF, 2'd0, 13'd0, 16'd0, 2'b00);
    drive(REF, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("aref_cnt2", aref_cnt, 16'd2);
    chk("aref_noerr", proto_err, 16'd0);

    // Test 1: page mode CL3, write 1..8 at col0, read back
    drive(MRS, 2'd0, 13'h037, 16'd0, 2'b00);
    chk("t1_mode", mode_done, 16'd1);
    drive(ACT, 2'd0, 13'd5, 16'd0, 2'b00);
    drive(WR, 2'd0, 13'd0, 16'd1, 2'b00);
    for (int i = 2; i <= 8; i++) drive(NOP, 2'd0, 13'd0, 16'(i), 2'b00);
    drive(BST, 2'd0, 13'd0, 16'hFFFF, 2'b00);
    drive(NOP, 2'd0, 13'd0, 16'hFFFF, 2'b00);
    drive(RD, 2'd0, 13'd0, 16'd0, 2'b00);
    for (int j = 1; j <= 11; j++) begin
      drive((j == 8) ? BST : NOP, 2'd0, 13'd0, 16'd0, 2'b00);
      if (j < 3 || j == 11) chk($sformatf("t1_oe_j%0d", j), dq_oe, 16'd0);
      else begin
        chk($sformatf("t1_oe_j%0d", j), dq_oe, 16'd1);
        chk($sformatf("t1_dq_j%0d", j), dq_out, 16'(j - 2));
      end
    end

    // Test 2: BL4 CL2, wrapped write at col6, read at col4 returns C,D,A,B
    drive(PRE, 2'd0, 13'h400, 16'd0, 2'b00);
    drive(MRS, 2'd0, 13'h022, 16'd0, 2'b00);
    drive(ACT, 2'd0, 13'd5, 16'd0, 2'b00);
    drive(WR, 2'd0, 13'd6, 16'h000A, 2'b00);
    drive(NOP, 2'd0, 13'd0, 16'h000B, 2'b00);
    drive(NOP, 2'd0, 13'd0, 16'h000C, 2'b00);
    drive(NOP, 2'd0, 13'd0, 16'h000D, 2'b00);
    drive(NOP, 2'd0, 13'd0, 16'hEEEE, 2'b00);
    drive(NOP, 2'd0, 13'd0, 16'hEEEE, 2'b00);
    drive(RD, 2'd0, 13'd4, 16'd0, 2'b00);
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t2_oe_j1", dq_oe, 16'd0);
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t2_dq0", dq_out, 16'h000C);
    chk("t2_oe_j2", dq_oe, 16'd1);
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t2_dq1", dq_out, 16'h000D);
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t2_dq2", dq_out, 16'h000A);
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t2_dq3", dq_out, 16'h000B);
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t2_oe_end", dq_oe, 16'd0);

    // Test 3: page write across the 511->0 wrap; read back with one cke-low cycle
    drive(PRE, 2'd0, 13'h400, 16'd0, 2'b00);
    drive(MRS, 2'd0, 13'h037, 16'd0, 2'b00);
    drive(ACT, 2'd1, 13'd2, 16'd0, 2'b00);
    drive(WR, 2'd1, 13'd510, 16'h0011, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'h0022, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'h0033, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'h0044, 2'b00);
    drive(BST, 2'd1, 13'd0, 16'hFFFF, 2'b00);
    drive(RD, 2'd1, 13'd510, 16'd0, 2'b00);
    for (int j = 1; j <= 8; j++) begin
      cke = (j == 2) ? 1'b0 : 1'b1;
      drive((j == 5) ? BST : NOP, 2'd1, 13'd0, 16'd0, 2'b00);
      if (j <= 3 || j == 8) chk($sformatf("t3_oe_j%0d", j), dq_oe, 16'd0);
      else chk($sformatf("t3_dq_j%0d", j), dq_out, 16'(8'h11 * (j - 3)));
    end
    cke = 1'b1;

    // Test 4: upper byte masked
    drive(WR, 2'd1, 13'd20, 16'h1234, 2'b00);
    drive(BST, 2'd1, 13'd0, 16'd0, 2'b00);
    drive(WR, 2'd1, 13'd20, 16'hABCD, 2'b10);
    drive(BST, 2'd1, 13'd0, 16'd0, 2'b00);
    drive(RD, 2'd1, 13'd20, 16'd0, 2'b00);
    drive(BST, 2'd1, 13'd0, 16'd0, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'd0, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'd0, 2'b00);
    chk("t4_dq", dq_out, 16'h12CD);
    drive(NOP, 2'd1, 13'd0, 16'd0, 2'b00);
    chk("t4_oe_end", dq_oe, 16'd0);

    // Test 6: reset mid page read, then re-init and read old data
    drive(RD, 2'd1, 13'd510, 16'd0, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'd0, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'd0, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'd0, 2'b00);
    chk("t6_oe_pre", dq_oe, 16'd1);
    chk("t6_dq_pre", dq_out, 16'h0011);
    #2 rst = 1'b1;
    #1;
    chk("t6_oe_async", dq_oe, 16'd0);
    chk("t6_mode", mode_done, 16'd0);
    chk("t6_aref", aref_cnt, 16'd0);
    tick();
    rst = 1'b0;
    drive(MRS, 2'd0, 13'h037, 16'd0, 2'b00);
    drive(ACT, 2'd1, 13'd2, 16'd0, 2'b00);
    drive(RD, 2'd1, 13'd510, 16'd0, 2'b00);
    drive(BST, 2'd1, 13'd0, 16'd0, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'd0, 2'b00);
    drive(NOP, 2'd1, 13'd0, 16'd0, 2'b00);
    chk("t6_readback", dq_out, 16'h0011);

    // Test 5: protocol errors, each from a clean reset
    chk("t5_perr0", proto_err, 16'd0);
    drive(RD, 2'd3, 13'd0, 16'd0, 2'b00);
    chk("t5_rd_closed", proto_err, 16'd1);
    for (int j = 1; j <= 4; j++) begin
      drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
      chk($sformatf("t5_no_oe_j%0d", j), dq_oe, 16'd0);
    end
    do_reset();
    chk("t5_perr_clr", proto_err, 16'd0);
    drive(MRS, 2'd0, 13'h034, 16'd0, 2'b00);
    chk("t5_mrs_bad", proto_err, 16'd1);
    chk("t5_mrs_bad_mode", mode_done, 16'd0);
    do_reset();
    drive(MRS, 2'd0, 13'h037, 16'd0, 2'b00);
    drive(ACT, 2'd2, 13'd0, 16'd0, 2'b00);
    chk("t5_act_ok", proto_err, 16'd0);
    drive(ACT, 2'd2, 13'd1, 16'd0, 2'b00);
    chk("t5_act_open", proto_err, 16'd1);
    do_reset();
    drive(MRS, 2'd0, 13'h037, 16'd0, 2'b00);
    drive(ACT, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t5_pre_aref", proto_err, 16'd0);
    drive(REF, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t5_aref_open", proto_err, 16'd1);
    chk("t5_aref_cnt", aref_cnt, 16'd1);
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    drive(NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    chk("t5_sticky", proto_err, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
